// File: rtl/mem_stage_pkg.sv
// Shared lc3b types for the memory-access stage: opcodes, word, instruction packet, FSM states.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDW  = 4'b0110,
        OP_STW  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic [2:0] dr;
        logic [2:0] sr1;
        logic [2:0] sr2;
        lc3b_word   pc;
    } lc3b_ipacket;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        HOLD = 2'd3
    } mem_state_t;

    // Opcode touches the data cache
    function automatic logic is_mem_op(input lc3b_opcode op);
        case (op)
            OP_LDB, OP_LDW, OP_LDI, OP_STB, OP_STW, OP_STI: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Opcode needs a pointer fetch before the real access
    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    // Opcode returns data to the register file
    function automatic logic is_load(input lc3b_opcode op);
        return (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDI);
    endfunction

    // Word-aligned cache address
    function automatic lc3b_word word_align(input lc3b_word a);
        return a & ~lc3b_word'(1);
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Formats raw cache read data into a load result (byte select + sign extension).
module load_formatter
    import mem_stage_pkg::*;
(
    input  lc3b_word rdata,
    input  logic     addr0,
    input  logic     is_byte,
    output lc3b_word result
);

    logic [7:0] w_byte;

    // Pick the addressed byte, sign-extend it for byte loads, else pass the word
    always_comb begin
        w_byte = addr0 ? rdata[15:8] : rdata[7:0];
        result = is_byte ? {{8{w_byte[7]}}, w_byte} : rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// lc3b MEM stage: data-cache handshake for loads/stores (incl. indirect) and load formatting.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  lc3b_ipacket ipacket,
    input  logic        bubble,
    input  lc3b_word    alu_in,
    input  lc3b_word    src_data,
    input  logic        stall_in,
    input  lc3b_word    dmem_rdata,
    input  logic        dmem_resp,
    output lc3b_word    dmem_address,
    output lc3b_word    dmem_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output lc3b_word    mem_data_out,
    output lc3b_word    alu_out,
    output lc3b_ipacket ipacket_out,
    output logic        stall_out
);

    mem_state_t r_state;
    lc3b_opcode r_op;
    logic       r_addr0;
    lc3b_word   r_src;
    lc3b_word   r_ptr;
    lc3b_word   r_result;
    lc3b_word   r_dmem_address;
    lc3b_word   r_dmem_wdata;
    logic       r_dmem_read;
    logic       r_dmem_write;
    logic [1:0] r_dmem_byte_enable;

    logic       w_mem_op;
    logic       w_final_resp;
    lc3b_word   w_fmt;
    lc3b_word   w_load_data;

    load_formatter u_load_formatter (
        .rdata   (dmem_rdata),
        .addr0   (r_addr0),
        .is_byte (r_op == OP_LDB),
        .result  (w_fmt)
    );

    // Decode: new memory op in the slot, last access completing, load result
    always_comb begin
        w_mem_op     = !bubble && is_mem_op(ipacket.opcode);
        w_final_resp = dmem_resp &&
                       (((r_state == ACC1) && !is_indirect(r_op)) || (r_state == ACC2));
        w_load_data  = is_load(r_op) ? w_fmt : '0;
    end

    // Stage outputs: stall while a request is outstanding, result to MEM/WB
    always_comb begin
        stall_out    = ((r_state == IDLE) && w_mem_op) ||
                       (((r_state == ACC1) || (r_state == ACC2)) && !w_final_resp);
        mem_data_out = '0;
        if (!rst_n)
            mem_data_out = '0;
        else if (w_final_resp)
            mem_data_out = w_load_data;
        else if (r_state == HOLD)
            mem_data_out = r_result;
        alu_out      = alu_in;
        ipacket_out  = ipacket;
    end

    // Access FSM with registered cache request outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_op               <= OP_BR;
            r_addr0            <= 1'b0;
            r_src              <= '0;
            r_ptr              <= '0;
            r_result           <= '0;
            r_dmem_address     <= '0;
            r_dmem_wdata       <= '0;
            r_dmem_read        <= 1'b0;
            r_dmem_write       <= 1'b0;
            r_dmem_byte_enable <= 2'b00;
        end else if (w_final_resp) begin
            // Access finished: capture result, drop request, hold if pipeline is stalled
            r_result           <= w_load_data;
            r_dmem_read        <= 1'b0;
            r_dmem_write       <= 1'b0;
            r_dmem_byte_enable <= 2'b00;
            r_state            <= stall_in ? HOLD : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_state            <= ACC1;
                        r_op               <= ipacket.opcode;
                        r_addr0            <= alu_in[0];
                        r_src              <= src_data;
                        r_dmem_address     <= word_align(alu_in);
                        r_dmem_wdata       <= '0;
                        r_dmem_byte_enable <= 2'b11;
                        r_dmem_read        <= 1'b1;
                        r_dmem_write       <= 1'b0;
                        case (ipacket.opcode)
                            OP_STW: begin
                                r_dmem_read  <= 1'b0;
                                r_dmem_write <= 1'b1;
                                r_dmem_wdata <= src_data;
                            end
                            OP_STB: begin
                                r_dmem_read        <= 1'b0;
                                r_dmem_write       <= 1'b1;
                                r_dmem_wdata       <= {src_data[7:0], src_data[7:0]};
                                r_dmem_byte_enable <= alu_in[0] ? 2'b10 : 2'b01;
                            end
                            default: ;
                        endcase
                    end
                end
                ACC1: begin
                    // Only indirect ops reach here on a response; go fetch at the pointer
                    if (dmem_resp) begin
                        r_state            <= ACC2;
                        r_ptr              <= dmem_rdata;
                        r_dmem_address     <= word_align(dmem_rdata);
                        r_dmem_byte_enable <= 2'b11;
                        if (r_op == OP_STI) begin
                            r_dmem_read  <= 1'b0;
                            r_dmem_write <= 1'b1;
                            r_dmem_wdata <= r_src;
                        end else begin
                            r_dmem_read  <= 1'b1;
                            r_dmem_write <= 1'b0;
                        end
                    end
                end
                ACC2: begin
                    r_dmem_address <= word_align(r_ptr);
                end
                HOLD: begin
                    if (!stall_in)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_address     = r_dmem_address;
    assign dmem_wdata       = r_dmem_wdata;
    assign dmem_read        = r_dmem_read;
    assign dmem_write       = r_dmem_write;
    assign dmem_byte_enable = r_dmem_byte_enable;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    lc3b_ipacket ipacket;
    logic        bubble;
    lc3b_word    alu_in;
    lc3b_word    src_data;
    logic        stall_in;
    lc3b_word    dmem_rdata;
    logic        dmem_resp;
    lc3b_word    dmem_address;
    lc3b_word    dmem_wdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    lc3b_word    mem_data_out;
    lc3b_word    alu_out;
    lc3b_ipacket ipacket_out;
    logic        stall_out;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ipacket          (ipacket),
        .bubble           (bubble),
        .alu_in           (alu_in),
        .src_data         (src_data),
        .stall_in         (stall_in),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_data_out     (mem_data_out),
        .alu_out          (alu_out),
        .ipacket_out      (ipacket_out),
        .stall_out        (stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a memory op in IDLE; stage must stall immediately, no request yet
    task automatic start_mem(input lc3b_opcode op, input logic [15:0] addr, input logic [15:0] src);
        @(negedge clk);
        ipacket.opcode = op;
        bubble         = 1'b0;
        alu_in         = addr;
        src_data       = src;
        dmem_resp      = 1'b0;
        #1;
        check("detect_stall", 16'(stall_out), 16'd1);
        check("detect_no_rd", 16'(dmem_read), 16'd0);
        check("detect_no_wr", 16'(dmem_write), 16'd0);
    endtask

    // Cycle waiting on the cache: request must be up and stable, slot contents ignored
    task automatic req_wait(input logic exp_rd, input logic exp_wr, input logic [15:0] exp_addr,
                            input logic [1:0] exp_be, input logic [15:0] exp_wdata);
        @(negedge clk);
        ipacket.opcode = OP_ADD;
        bubble         = 1'b1;
        dmem_resp      = 1'b0;
        #1;
        check("req_read", 16'(dmem_read), 16'(exp_rd));
        check("req_write", 16'(dmem_write), 16'(exp_wr));
        check("req_addr", dmem_address, exp_addr);
        check("req_be", 16'(dmem_byte_enable), 16'(exp_be));
        check("req_stall", 16'(stall_out), 16'd1);
        if (exp_wr)
            check("req_wdata", dmem_wdata, exp_wdata);
    endtask

    // Cache response cycle
    task automatic resp_cycle(input logic [15:0] rdata, input logic sin,
                              input logic exp_stall, input logic [15:0] exp_mdo);
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        stall_in   = sin;
        #1;
        check("resp_stall", 16'(stall_out), 16'(exp_stall));
        check("resp_mdo", mem_data_out, exp_mdo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        ipacket    = '0;
        ipacket.opcode = OP_ADD;
        bubble     = 1'b1;
        alu_in     = '0;
        src_data   = '0;
        stall_in   = 1'b0;
        dmem_rdata = '0;
        dmem_resp  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_read", 16'(dmem_read), 16'd0);
        check("rst_write", 16'(dmem_write), 16'd0);
        check("rst_addr", dmem_address, 16'h0000);
        check("rst_be", 16'(dmem_byte_enable), 16'd0);
        check("rst_mdo", mem_data_out, 16'h0000);
        check("rst_stall_idle", 16'(stall_out), 16'd0);
        ipacket.opcode = OP_LDW;
        bubble = 1'b0;
        #1;
        check("rst_stall_memop", 16'(stall_out), 16'd1);
        bubble = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory op passes straight through
        @(negedge clk);
        ipacket.opcode = OP_ADD;
        bubble = 1'b0;
        alu_in = 16'h9999;
        #1;
        check("alu_stall", 16'(stall_out), 16'd0);
        check("alu_pass", alu_out, 16'h9999);
        check("ipkt_pass", 16'(ipacket_out.opcode), 16'(OP_ADD));
        check("alu_mdo", mem_data_out, 16'h0000);

        // LDW
        start_mem(OP_LDW, 16'h1234, 16'h0000);
        req_wait(1'b1, 1'b0, 16'h1234, 2'b11, 16'h0000);
        resp_cycle(16'hBEEF, 1'b0, 1'b0, 16'hBEEF);

        // LDB high byte, back-to-back
        start_mem(OP_LDB, 16'h2001, 16'h0000);
        req_wait(1'b1, 1'b0, 16'h2000, 2'b11, 16'h0000);
        resp_cycle(16'h80FF, 1'b0, 1'b0, 16'hFF80);

        // LDB low byte
        start_mem(OP_LDB, 16'h2000, 16'h0000);
        req_wait(1'b1, 1'b0, 16'h2000, 2'b11, 16'h0000);
        resp_cycle(16'h7F34, 1'b0, 1'b0, 16'h0034);

        // STB odd / even address
        start_mem(OP_STB, 16'h3003, 16'h00A5);
        req_wait(1'b0, 1'b1, 16'h3002, 2'b10, 16'hA5A5);
        resp_cycle(16'hFFFF, 1'b0, 1'b0, 16'h0000);
        start_mem(OP_STB, 16'h3002, 16'h1234);
        req_wait(1'b0, 1'b1, 16'h3002, 2'b01, 16'h3434);
        resp_cycle(16'hFFFF, 1'b0, 1'b0, 16'h0000);

        // STW
        start_mem(OP_STW, 16'h6001, 16'hCAFE);
        req_wait(1'b0, 1'b1, 16'h6000, 2'b11, 16'hCAFE);
        resp_cycle(16'hFFFF, 1'b0, 1'b0, 16'h0000);

        // LDI: pointer read then data read, no gap
        start_mem(OP_LDI, 16'h4000, 16'h0000);
        req_wait(1'b1, 1'b0, 16'h4000, 2'b11, 16'h0000);
        resp_cycle(16'h5000, 1'b0, 1'b1, 16'h0000);
        req_wait(1'b1, 1'b0, 16'h5000, 2'b11, 16'h0000);
        resp_cycle(16'h0042, 1'b0, 1'b0, 16'h0042);

        // LDW completing under an external stall: result held
        start_mem(OP_LDW, 16'h1000, 16'h0000);
        req_wait(1'b1, 1'b0, 16'h1000, 2'b11, 16'h0000);
        resp_cycle(16'h5A5A, 1'b1, 1'b0, 16'h5A5A);
        @(negedge clk);
        dmem_resp = 1'b1;
        dmem_rdata = 16'h1111;
        ipacket.opcode = OP_LDW;
        bubble = 1'b0;
        #1;
        check("hold_mdo", mem_data_out, 16'h5A5A);
        check("hold_stall", 16'(stall_out), 16'd0);
        check("hold_no_rd", 16'(dmem_read), 16'd0);
        @(negedge clk);
        dmem_resp = 1'b0;
        bubble = 1'b1;
        stall_in = 1'b0;
        #1;
        check("hold_exit_mdo", mem_data_out, 16'h5A5A);
        check("hold_exit_rd", 16'(dmem_read), 16'd0);
        @(negedge clk);
        #1;
        check("post_hold_mdo", mem_data_out, 16'h0000);
        check("post_hold_rd", 16'(dmem_read), 16'd0);

        // STI with stall across done: HOLD, no third request
        start_mem(OP_STI, 16'h7000, 16'h1111);
        req_wait(1'b1, 1'b0, 16'h7000, 2'b11, 16'h0000);
        resp_cycle(16'h7100, 1'b1, 1'b1, 16'h0000);
        req_wait(1'b0, 1'b1, 16'h7100, 2'b11, 16'h1111);
        resp_cycle(16'hFFFF, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dmem_resp = 1'b0;
            #1;
            check("sti_hold_rd", 16'(dmem_read), 16'd0);
            check("sti_hold_wr", 16'(dmem_write), 16'd0);
            check("sti_hold_stall", 16'(stall_out), 16'd0);
            check("sti_hold_mdo", mem_data_out, 16'h0000);
        end
        @(negedge clk);
        stall_in = 1'b0;
        #1;
        check("sti_exit_wr", 16'(dmem_write), 16'd0);

        // Reset during ACC2, late response ignored
        start_mem(OP_LDI, 16'h4000, 16'h0000);
        req_wait(1'b1, 1'b0, 16'h4000, 2'b11, 16'h0000);
        resp_cycle(16'h5000, 1'b0, 1'b1, 16'h0000);
        @(negedge clk);
        dmem_resp = 1'b0;
        rst_n = 1'b0;
        #1;
        check("acc2_rd_pre_rst", 16'(dmem_read), 16'd1);
        check("acc2_addr_pre_rst", dmem_address, 16'h5000);
        check("rst_force_mdo", mem_data_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_resp = 1'b1;
        dmem_rdata = 16'h1234;
        ipacket.opcode = OP_LDW;
        bubble = 1'b1;
        #1;
        check("midrst_rd", 16'(dmem_read), 16'd0);
        check("midrst_wr", 16'(dmem_write), 16'd0);
        check("midrst_stall", 16'(stall_out), 16'd0);
        check("midrst_mdo", mem_data_out, 16'h0000);
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        check("late_resp_rd", 16'(dmem_read), 16'd0);
        check("late_resp_addr", dmem_address, 16'h0000);
        check("late_resp_stall", 16'(stall_out), 16'd0);
        check("late_resp_mdo", mem_data_out, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
